// File: rtl/vector_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vector_loader_pkg
// Purpose  : Shared lane width and loader/accumulator state encodings.
// Contents : VARWIDTH  - lane width in bits (32)
//            state_t   - STATE_LOAD (0), STATE_READY (1)
// Revision : 1.0 - initial release
// ============================================================================
package vector_loader_pkg;

  localparam int VARWIDTH = 32;

  typedef enum logic [0:0] {
    STATE_LOAD  = 1'b0,
    STATE_READY = 1'b1
  } state_t;

endpackage : vector_loader_pkg
`default_nettype wire

// File: rtl/vector_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_loader_if
// Purpose  : Producer/consumer bundle of the vector loader.
// Ports    : in_valid/in_word/last/in_ready - word handshake (producer side)
//            ack/rdy/vals/count              - vector handshake (consumer side)
// Modports : master - environment driving words and ack
//            slave  - the loader itself
// Revision : 1.0 - initial release
// ============================================================================
interface vector_loader_if
  import vector_loader_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic                      in_valid;
  logic [VARWIDTH-1:0]       in_word;
  logic                      last;
  logic                      in_ready;
  logic                      ack;
  logic                      rdy;
  logic [VARWIDTH*WIDTH-1:0] vals;
  logic [7:0]                count;

  modport master (
    output in_valid, in_word, last, ack,
    input  in_ready, rdy, vals, count
  );

  modport slave (
    input  in_valid, in_word, last, ack,
    output in_ready, rdy, vals, count
  );

endinterface : vector_loader_if
`default_nettype wire

// File: rtl/vector_loader_adder8.sv
`default_nettype none
// ============================================================================
// Module   : adder8
// Purpose  : 8-bit ripple adder with carry in/out.
// Ports    : a, b   - operands
//            cin    - carry in
//            sum    - 8-bit sum
//            cout   - carry out
// Revision : 1.0 - initial release
// ============================================================================
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule : adder8
`default_nettype wire

// File: rtl/vector_loader.sv
`default_nettype none
// ============================================================================
// Module   : vector_loader
// Purpose  : Collects a stream of 32-bit words into a WIDTH-lane vector and
//            presents it to a consumer until acknowledged.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            EN   - global enable; all state freezes while low
//            bus  - vector_loader_if.slave (word and vector handshakes)
// Params   : WIDTH - lane count, even, 2..128
// Macro    : LOADER_ZEROPAD_EN - an accepted word with last=1 ends the vector
//            early; unwritten lanes stay 0
// Revision : 1.0 - initial release
// ============================================================================
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EN,
  vector_loader_if.slave  bus
);

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;

  logic       w_accept;
  logic       w_clear;
  logic       w_full;
  logic       w_short_end;
  logic [7:0] w_sum;
  logic       w_cout;

  // The increment result is also used to spot the final lane: count+1 == WIDTH
  // is the same as count == WIDTH-1, and reusing the carry keeps the compare
  // 9 bits wide so it can never alias.
  adder8 u_inc (
    .a    (count_q),
    .b    (8'd0),
    .cin  (1'b1),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign bus.in_ready = !rst && EN && (state_q == STATE_LOAD);
  assign w_accept     = bus.in_ready && bus.in_valid;
  assign w_clear      = EN && (state_q == STATE_READY) && bus.ack;
  assign w_full       = ({w_cout, w_sum} == 9'(WIDTH));

`ifdef LOADER_ZEROPAD_EN
  assign w_short_end  = bus.last;
`else
  // last has no effect in this build; the AND keeps the input formally read.
  assign w_short_end  = bus.last & 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      STATE_LOAD: begin
        if (w_accept) begin
          count_d = w_sum;
          if (w_full || w_short_end) begin
            state_d = STATE_READY;
          end
        end
      end
      STATE_READY: begin
        if (w_clear) begin
          count_d = 8'd0;
          state_d = STATE_LOAD;
        end
      end
      default: begin
        state_d = STATE_LOAD;
        count_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_LOAD;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // One register per lane; a lane is written only when count points at it,
  // so each lane is loaded at most once per vector and unwritten lanes keep
  // the zero left by reset or ack.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [VARWIDTH-1:0] lane_q, lane_d;

    always_comb begin
      lane_d = lane_q;
      if (w_clear) begin
        lane_d = '0;
      end else if (w_accept && (count_q == 8'(i))) begin
        lane_d = bus.in_word;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign bus.vals[(i+1)*VARWIDTH-1 : i*VARWIDTH] = lane_q;
  end

  assign bus.rdy   = (state_q == STATE_READY);
  assign bus.count = count_q;

endmodule : vector_loader
`default_nettype wire

// File: tb/tb_vector_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_loader
// Purpose  : Directed self-checking bench for vector_loader (WIDTH=16).
//            Completed vectors are pushed to a scoreboard queue as their final
//            word is driven and popped when rdy is observed.
// Macro    : LOADER_ZEROPAD_EN - selects the expected short-vector behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_loader;
  import vector_loader_pkg::*;

  localparam int WIDTH = 16;
  localparam int VW    = VARWIDTH * WIDTH;

  typedef struct packed {
    logic [VW-1:0] vec;
    logic [7:0]    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic EN  = 1'b0;

  vector_loader_if #(.WIDTH(WIDTH)) bus ();

  vector_loader #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .EN  (EN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [31:0]   m_lane [WIDTH];
  int            m_count;
  logic [VW-1:0] held;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack_model();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i*VARWIDTH +: VARWIDTH] = m_lane[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < WIDTH; i++) m_lane[i] = '0;
    m_count = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted word for one cycle and update the reference vector.
  task automatic load_word(input logic [31:0] w, input logic l);
    logic done;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.last     = l;
    m_lane[m_count] = w;
    m_count++;
    done = (m_count == WIDTH);
`ifdef LOADER_ZEROPAD_EN
    if (l) done = 1'b1;
`endif
    if (done) sb.push_back({pack_model(), 8'(m_count)});
    step();
    bus.in_valid = 1'b0;
    bus.last     = 1'b0;
  endtask

  task automatic expect_vector(input string tag);
    exp_t e;
    check({tag, "_rdy"}, VW'(bus.rdy), VW'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed=rdy expected=no vector pending", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_vals"}, bus.vals, e.vec);
      check({tag, "_count"}, VW'(bus.count), VW'(e.cnt));
      held = e.vec;
    end
  endtask

  task automatic do_ack(input string tag);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    model_clear();
    check({tag, "_rdy0"}, VW'(bus.rdy), VW'(0));
    check({tag, "_cnt0"}, VW'(bus.count), VW'(0));
    check({tag, "_vals0"}, bus.vals, '0);
    check({tag, "_inrdy"}, VW'(bus.in_ready), VW'(1));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.last     = 1'b0;
    bus.ack      = 1'b0;
    model_clear();
    held = '0;

    // Power-on reset
    step();
    step();
    check("por_rdy", VW'(bus.rdy), VW'(0));
    check("por_inrdy", VW'(bus.in_ready), VW'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("en0_inrdy", VW'(bus.in_ready), VW'(0));
    EN = 1'b1;
    #1;
    check("en1_inrdy", VW'(bus.in_ready), VW'(1));

    // Reset asserted mid-clock while a partial vector is loaded
    for (int i = 0; i < 3; i++) load_word(32'h900 + 32'(i), 1'b0);
    check("pre_rst_cnt", VW'(bus.count), VW'(3));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rdy", VW'(bus.rdy), VW'(0));
    check("async_cnt", VW'(bus.count), VW'(0));
    check("async_vals", bus.vals, '0);
    check("async_inrdy", VW'(bus.in_ready), VW'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_inrdy", VW'(bus.in_ready), VW'(1));

    // Full load 1..16, rdy exactly one cycle after the 16th word
    for (int i = 1; i <= WIDTH; i++) begin
      load_word(32'(i), 1'b0);
      if (i < WIDTH) check("full_rdy_early", VW'(bus.rdy), VW'(0));
    end
    expect_vector("full");
    check("full_lane0", VW'(bus.vals[31:0]), VW'(1));
    check("full_lane15", VW'(bus.vals[VW-1 -: 32]), VW'(16));
    check("full_inrdy", VW'(bus.in_ready), VW'(0));

    // Backpressure: in_valid ignored while READY
    bus.in_valid = 1'b1;
    bus.in_word  = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_vals", bus.vals, held);
      check("bp_cnt", VW'(bus.count), VW'(16));
    end
    // ack coincident with in_valid must not load the word
    do_ack("bp_ack");
    bus.in_valid = 1'b0;
    load_word(32'h55, 1'b0);
    check("bp_lane0", VW'(bus.vals[31:0]), VW'(32'h55));
    check("bp_cnt1", VW'(bus.count), VW'(1));
    for (int i = 1; i < WIDTH; i++) load_word(32'h100 + 32'(i), 1'b0);
    expect_vector("bp_vec");
    do_ack("bp_ack2");

    // EN gating mid-vector
    for (int i = 0; i < 8; i++) load_word(32'h200 + 32'(i), 1'b0);
    EN = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_word  = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_cnt", VW'(bus.count), VW'(8));
      check("en_inrdy", VW'(bus.in_ready), VW'(0));
    end
    bus.in_valid = 1'b0;
    EN = 1'b1;
    for (int i = 8; i < WIDTH; i++) load_word(32'h200 + 32'(i), 1'b0);
    expect_vector("en_vec");
    // ack with EN low is not processed
    EN = 1'b0;
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("en_ack_rdy", VW'(bus.rdy), VW'(1));
    check("en_ack_vals", bus.vals, held);
    EN = 1'b1;
    do_ack("en_ack");

    // Short vector with last on the 5th word
    for (int i = 0; i < 5; i++) load_word(32'hA + 32'(i), (i == 4));
`ifdef LOADER_ZEROPAD_EN
    expect_vector("zp");
    check("zp_upper0", VW'(bus.vals[VW-1:5*32]), '0);
`else
    check("nozp_rdy", VW'(bus.rdy), VW'(0));
    check("nozp_cnt", VW'(bus.count), VW'(5));
    for (int i = 5; i < WIDTH; i++) begin
      check("nozp_rdy_early", VW'(bus.rdy), VW'(0));
      load_word(32'h300 + 32'(i), 1'b0);
    end
    expect_vector("nozp");
`endif
    do_ack("zp_ack");

    // Mid-vector reset discards the partial vector; ack in LOAD ignored
    for (int i = 0; i < 10; i++) load_word(32'h400 + 32'(i), 1'b0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("ld_ack_cnt", VW'(bus.count), VW'(10));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mvr_rdy", VW'(bus.rdy), VW'(0));
    check("mvr_cnt", VW'(bus.count), VW'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      check("mvr_rdy_early", VW'(bus.rdy), VW'(0));
      load_word(32'h77 + 32'(i), 1'b0);
    end
    expect_vector("mvr");
    check("mvr_lane0", VW'(bus.vals[31:0]), VW'(32'h77));
    do_ack("mvr_ack");

    check("sb_empty", VW'(sb.size()), VW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vector_loader
`default_nettype wire
